// File: rtl/fxp_addsub_byte_engine.sv
// ---------------------------------------------------------------------------
// fxp_addsub_byte_engine
//
// Purpose:
//    Byte-serial front end and arithmetic engine for signed fixed-point
//    add/sub. A command frame is three bytes (opcode, A, B) delivered over a
//    valid/ready byte stream. The engine returns one result per frame, with
//    an overflow flag, and counts the results taken by the downstream side.
//    In saturating mode an overflowing result is clamped to the most
//    positive or most negative value. Otherwise it wraps modulo 2^DATA_WIDTH.
//
// Parameters:
//    DATA_WIDTH  operand/result width, signed two's complement
//    SATURATE    1: clamp on overflow, 0: wrap
//    CNT_WIDTH   width of the completed-frame counter (wraps silently)
//
// Ports:
//    i_clk       rising-edge clock
//    i_reset_n   asynchronous active-low reset
//    i_data      input byte stream (opcode, A, B in that order)
//    i_valid     i_data is valid
//    o_ready     engine accepts i_data this cycle
//    o_data      result
//    o_valid     o_data/o_ovf are valid
//    i_ready     downstream accepts the result
//    o_ovf       overflow occurred for the current result
//    o_count     number of results accepted downstream
// ---------------------------------------------------------------------------
module fxp_addsub_byte_engine #(
   parameter int DATA_WIDTH = 8,
   parameter int SATURATE   = 1,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_ovf,
   output logic [CNT_WIDTH-1:0]  o_count
);

   typedef enum logic [2:0] {
      S_OP,
      S_A,
      S_B,
      S_CALC,
      S_OUT
   } state_t;

   state_t state_q;
   state_t state_d;

   logic                  op_q;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;

   logic                  in_xfer;
   logic                  out_xfer;

   logic [DATA_WIDTH:0]   a_ext;
   logic [DATA_WIDTH:0]   b_ext;
   logic [DATA_WIDTH:0]   raw_res;
   logic                  ovf;
   logic [DATA_WIDTH-1:0] result;

   localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0]  CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   assign in_xfer  = i_valid && o_ready;
   assign out_xfer = o_valid && i_ready;

   // State register. A reset in the middle of a frame throws away any
   // partially collected operands, so the next byte is always an opcode.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_OP;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic. The three input states advance only on a byte
   // transfer. CALC always takes exactly one cycle. OUT waits for the
   // downstream handshake.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_OP:    if (in_xfer)  state_d = S_A;
         S_A:     if (in_xfer)  state_d = S_B;
         S_B:     if (in_xfer)  state_d = S_CALC;
         S_CALC:                state_d = S_OUT;
         S_OUT:   if (out_xfer) state_d = S_OP;
         default:               state_d = S_OP;
      endcase
   end

   // Output decode. There is no skid buffer: the input side is closed from
   // CALC until the result has been taken.
   always_comb begin
      o_ready = 1'b0;
      case (state_q)
         S_OP, S_A, S_B: o_ready = 1'b1;
         default:        o_ready = 1'b0;
      endcase
   end

   // Operand capture. Only bit 0 of the opcode byte carries meaning.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         op_q <= 1'b0;
         a_q  <= '0;
         b_q  <= '0;
      end else if (in_xfer) begin
         case (state_q)
            S_OP:    op_q <= i_data[0];
            S_A:     a_q  <= i_data;
            S_B:     b_q  <= i_data;
            default: ;
         endcase
      end
   end

   // Work one bit wider than the operands so the true sum or difference is
   // always representable. Overflow shows up as the two top bits disagreeing,
   // and the extra top bit then gives the true sign, which picks the clamp.
   always_comb begin
      a_ext   = {a_q[DATA_WIDTH-1], a_q};
      b_ext   = {b_q[DATA_WIDTH-1], b_q};
      raw_res = op_q ? (a_ext - b_ext) : (a_ext + b_ext);
      ovf     = raw_res[DATA_WIDTH] ^ raw_res[DATA_WIDTH-1];
      result  = raw_res[DATA_WIDTH-1:0];
      if ((SATURATE != 0) && ovf) begin
         result = raw_res[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
      end
   end

   // Result registers and counter. o_data/o_ovf load once in CALC and then
   // stay put for the whole OUT wait. The counter ticks once per accepted
   // result and rolls over without a flag.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_data  <= '0;
         o_ovf   <= 1'b0;
         o_valid <= 1'b0;
         o_count <= '0;
      end else begin
         if (state_q == S_CALC) begin
            o_data  <= result;
            o_ovf   <= ovf;
            o_valid <= 1'b1;
         end else if ((state_q == S_OUT) && out_xfer) begin
            o_valid <= 1'b0;
            o_count <= o_count + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_fxp_addsub_byte_engine.sv
// ---------------------------------------------------------------------------
// tb_fxp_addsub_byte_engine
//
// Directed bench for the fixed-point add/sub byte engine. Two instances share
// the same stimulus: one saturating and one wrapping. This lets every frame
// check both overflow behaviours against hand-computed results.
// ---------------------------------------------------------------------------
module tb_fxp_addsub_byte_engine;

   logic       clk;
   logic       rst_n;
   logic [7:0] i_data;
   logic       i_valid;
   logic       i_ready;

   logic       ready_s, valid_s, ovf_s;
   logic [7:0] data_s, count_s;
   logic       ready_w, valid_w, ovf_w;
   logic [7:0] data_w, count_w;

   int         test_count;
   int         fail_count;
   logic [7:0] exp_count;

   fxp_addsub_byte_engine #(.DATA_WIDTH(8), .SATURATE(1), .CNT_WIDTH(8)) dut_sat (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .o_ready   (ready_s),
      .o_data    (data_s),
      .o_valid   (valid_s),
      .i_ready   (i_ready),
      .o_ovf     (ovf_s),
      .o_count   (count_s)
   );

   fxp_addsub_byte_engine #(.DATA_WIDTH(8), .SATURATE(0), .CNT_WIDTH(8)) dut_wrap (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .o_ready   (ready_w),
      .o_data    (data_w),
      .o_valid   (valid_w),
      .i_ready   (i_ready),
      .o_ovf     (ovf_w),
      .o_count   (count_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      test_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Offer one byte and hold it until the engine takes it, within a bounded
   // number of cycles. Returns 1 ns after the accepting edge.
   task automatic applyStimulus(input logic [7:0] value);
      int waited;
      waited  = 0;
      i_data  = value;
      i_valid = 1'b1;
      while (!ready_s && waited < 20) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!ready_s) begin
         test_count++;
         fail_count++;
         $display("[TB] FAIL ready_timeout: observed o_ready 0 for %0d cycles, expected 1", waited);
      end else begin
         @(posedge clk); #1;
      end
      i_valid = 1'b0;
      i_data  = 8'h00;
   endtask

   // One complete frame. It checks the latency, the result in both modes,
   // stability while downstream stalls for hold_cycles, and the counter.
   task automatic runFrame(input string tag, input logic [7:0] op,
                           input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_sat, input logic [7:0] exp_wrap,
                           input logic exp_ovf, input int hold_cycles);
      applyStimulus(op);
      applyStimulus(a);
      applyStimulus(b);
      checkOutput({tag, "_calc_valid"}, valid_s, 0);
      checkOutput({tag, "_calc_ready"}, ready_s, 0);
      @(posedge clk); #1;
      checkOutput({tag, "_valid_s"}, valid_s, 1);
      checkOutput({tag, "_valid_w"}, valid_w, 1);
      checkOutput({tag, "_data_s"},  data_s,  exp_sat);
      checkOutput({tag, "_data_w"},  data_w,  exp_wrap);
      checkOutput({tag, "_ovf_s"},   ovf_s,   exp_ovf);
      checkOutput({tag, "_ovf_w"},   ovf_w,   exp_ovf);
      for (int i = 0; i < hold_cycles; i++) begin
         i_valid = 1'b1;
         i_data  = 8'h55;
         @(posedge clk); #1;
         checkOutput({tag, "_hold_data"},  data_s,  exp_sat);
         checkOutput({tag, "_hold_ovf"},   ovf_s,   exp_ovf);
         checkOutput({tag, "_hold_valid"}, valid_s, 1);
         checkOutput({tag, "_hold_ready"}, ready_s, 0);
         checkOutput({tag, "_hold_count"}, count_s, exp_count);
      end
      i_valid = 1'b0;
      i_data  = 8'h00;
      i_ready = 1'b1;
      @(posedge clk); #1;
      i_ready = 1'b0;
      exp_count++;
      checkOutput({tag, "_count_s"},    count_s, exp_count);
      checkOutput({tag, "_count_w"},    count_w, exp_count);
      checkOutput({tag, "_post_valid"}, valid_s, 0);
      checkOutput({tag, "_post_ready"}, ready_s, 1);
   endtask

   initial begin
      test_count = 0;
      fail_count = 0;
      exp_count  = 8'h00;
      rst_n      = 1'b0;
      i_data     = 8'h00;
      i_valid    = 1'b0;
      i_ready    = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_data",  data_s,  0);
      checkOutput("rst_valid", valid_s, 0);
      checkOutput("rst_ovf",   ovf_s,   0);
      checkOutput("rst_count", count_s, 0);
      checkOutput("rst_ready", ready_s, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checkOutput("rel_ready", ready_s, 1);

      // One frame so the counter is non-zero, then abort a frame after A.
      runFrame("pre", 8'h00, 8'h10, 8'h20, 8'h30, 8'h30, 1'b0, 0);
      applyStimulus(8'h00);
      applyStimulus(8'h10);
      #2 rst_n = 1'b0;
      #2;
      checkOutput("midrst_count", count_s, 0);
      checkOutput("midrst_valid", valid_s, 0);
      @(posedge clk); #1;
      rst_n     = 1'b1;
      exp_count = 8'h00;
      @(posedge clk); #1;
      checkOutput("midrst_ready", ready_s, 1);
      runFrame("midrst_frame", 8'h00, 8'h10, 8'h20, 8'h30, 8'h30, 1'b0, 0);

      // Basic add/sub and overflow in both directions.
      runFrame("add",      8'h00, 8'h10, 8'h20, 8'h30, 8'h30, 1'b0, 0);
      runFrame("sub",      8'h01, 8'h10, 8'h20, 8'hF0, 8'hF0, 1'b0, 0);
      runFrame("add_ovf",  8'h00, 8'h70, 8'h20, 8'h7F, 8'h90, 1'b1, 0);
      runFrame("sub_ovf",  8'h01, 8'h80, 8'h01, 8'h80, 8'h7F, 1'b1, 0);
      // Extremes: -128 + -128, 127 - (-128), 127 + (-127).
      runFrame("min_min",  8'h00, 8'h80, 8'h80, 8'h80, 8'h00, 1'b1, 0);
      runFrame("max_subm", 8'h01, 8'h7F, 8'h80, 8'h7F, 8'hFF, 1'b1, 0);
      runFrame("zero",     8'h00, 8'h7F, 8'h81, 8'h00, 8'h00, 1'b0, 0);
      // Opcode upper bits carry no meaning.
      runFrame("op_fe",    8'hFE, 8'h10, 8'h20, 8'h30, 8'h30, 1'b0, 0);
      runFrame("op_03",    8'h03, 8'h10, 8'h20, 8'hF0, 8'hF0, 1'b0, 0);

      // Downstream stalls for five cycles while junk bytes are offered.
      runFrame("stall",    8'h00, 8'h70, 8'h20, 8'h7F, 8'h90, 1'b1, 5);
      runFrame("after",    8'h01, 8'h20, 8'h08, 8'h18, 8'h18, 1'b0, 0);

      // i_ready with no result pending does nothing.
      i_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      i_ready = 1'b0;
      checkOutput("idle_ready_count", count_s, exp_count);
      checkOutput("idle_ready_valid", valid_s, 0);

      // Keep completing frames (A + 0 = A) until the counter wraps to zero.
      for (int j = 0; j < 300; j++) begin
         runFrame("wrap_loop", 8'h00, j[7:0], 8'h00, j[7:0], j[7:0], 1'b0, 0);
         if (exp_count == 8'h00) break;
      end
      checkOutput("count_wrap_s", count_s, 0);
      checkOutput("count_wrap_w", count_w, 0);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
